gather_vc_allocator: RTL

- Output-VC allocator for one router output port; the responder to the per-input controllers' VC requests.
- Accepts multi-hot candidate-VC requests from NI input controllers and grants each winner exactly one free output VC, same cycle.
- Holds each granted VC busy until the output side reports that VC's tail flit has departed.
- Sits between the input controllers (req_vc / sel_out_vc / vc_granted) and the output port / crossbar.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/gather_vc_allocator.sv | 117 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: VC count, flit-type encodings and a one-hot decoder.
package noc_pkg;

  // Virtual channels per router port.
  localparam int CN = 4;

  // Flit-type encodings carried in the flit header field.
  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  // Index of the set bit of a one-hot vector (0 when the vector is zero).
  // Shifts instead of variable bit-selects so the loop body stays constant-indexed.
  function automatic int onehot_to_idx(input logic [31:0] oh);
    logic [31:0] v;
    int          idx;
    v   = oh;
    idx = 0;
    for (int k = 0; k < 32; k++) begin
      if (v[0]) idx = k;
      v = v >> 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] src;

  // Thermometer mask of positions at or above the pointer.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask_hi[gi] = ((PW+1)'(gi) >= {1'b0, ptr});
    end
  endgenerate

  // Prefer requests at/after the pointer; otherwise wrap to the lowest request.
  assign req_hi = req & mask_hi;
  assign src    = (|req_hi) ? req_hi : req;
  // Isolate the lowest set bit.
  assign gnt    = src & (~src + N'(1));

endmodule

// File: rtl/gather_vc_allocator.sv
// Output-VC allocator for one router output port. Two-stage separable
// round-robin allocation (input picks a VC, VC picks an input), zero-cycle
// grant, VC held busy until its tail flit departs.
module gather_vc_allocator
  import noc_pkg::*;
#(
  parameter int NI = 5,
  parameter int CN = noc_pkg::CN,
  parameter int IW = $clog2(NI)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NI*CN-1:0] req_vc,
  output logic [NI*CN-1:0] sel_out_vc,
  output logic [NI-1:0]    vc_granted,
  input  logic [CN-1:0]    vc_release,
  output logic [CN-1:0]    vc_busy,
  output logic [CN*IW-1:0] vc_owner,
  output logic             err_release
);

  localparam int CW = $clog2(CN);

  // Registered allocation state and its next values.
  logic [CN-1:0]          vc_busy_reg, vc_busy_next;
  logic [CN-1:0][IW-1:0]  vc_owner_reg, vc_owner_next;
  logic [CN-1:0][IW-1:0]  vp_reg, vp_next;
  logic [NI-1:0][CW-1:0]  ip_reg, ip_next;
  logic                   err_release_reg, err_release_next;

  // Stage-1 (per input) and stage-2 (per VC) arbitration signals.
  logic [NI-1:0][CN-1:0]  eligible;
  logic [NI-1:0][CN-1:0]  pick;
  logic [NI-1:0][CN-1:0]  sel_raw;
  logic [CN-1:0][NI-1:0]  cand;
  logic [CN-1:0][NI-1:0]  win;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_input
      logic [CW-1:0] pick_idx;

      // Only free VCs are eligible; a VC released this cycle is still busy.
      assign eligible[gi] = req_vc[gi*CN +: CN] & ~vc_busy_reg;

      rr_arbiter #(.N(CN)) u_in_arb (
        .req (eligible[gi]),
        .ptr (ip_reg[gi]),
        .gnt (pick[gi])
      );

      // Input pointer advances past the VC just won; explicit wrap at CN-1.
      assign pick_idx    = CW'(onehot_to_idx(32'(pick[gi])));
      assign ip_next[gi] = (|sel_raw[gi])
                         ? ((pick_idx == CW'(CN-1)) ? '0 : pick_idx + CW'(1))
                         : ip_reg[gi];

      // Grants are suppressed while reset is held.
      assign sel_out_vc[gi*CN +: CN] = rst ? '0 : sel_raw[gi];
      assign vc_granted[gi]          = |sel_out_vc[gi*CN +: CN];

      // Transpose between input-major and VC-major views.
      for (genvar gj = 0; gj < CN; gj++) begin : g_xpose
        assign cand[gj][gi]    = pick[gi][gj];
        assign sel_raw[gi][gj] = win[gj][gi];
      end
    end

    for (genvar gi = 0; gi < CN; gi++) begin : g_vc
      logic [IW-1:0] win_idx;
      logic          win_any;

      // Losers of this VC get nothing this cycle (no fallback).
      rr_arbiter #(.N(NI)) u_vc_arb (
        .req (cand[gi]),
        .ptr (vp_reg[gi]),
        .gnt (win[gi])
      );

      assign win_any = |win[gi];
      assign win_idx = IW'(onehot_to_idx(32'(win[gi])));

      // Grant sets busy; release clears it only if no grant (grant needs busy=0).
      assign vc_busy_next[gi]  = win_any ? 1'b1
                               : (vc_release[gi] ? 1'b0 : vc_busy_reg[gi]);
      assign vc_owner_next[gi] = win_any ? win_idx : vc_owner_reg[gi];
      // VC pointer moves past the winner; explicit wrap at NI-1.
      assign vp_next[gi]       = win_any
                               ? ((win_idx == IW'(NI-1)) ? '0 : win_idx + IW'(1))
                               : vp_reg[gi];
    end
  endgenerate

  // Releasing a VC that is not busy is a protocol error; sticky until reset.
  assign err_release_next = err_release_reg | (|(vc_release & ~vc_busy_reg));

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc_busy_reg     <= '0;
      vc_owner_reg    <= '0;
      vp_reg          <= '0;
      ip_reg          <= '0;
      err_release_reg <= 1'b0;
    end else begin
      vc_busy_reg     <= vc_busy_next;
      vc_owner_reg    <= vc_owner_next;
      vp_reg          <= vp_next;
      ip_reg          <= ip_next;
      err_release_reg <= err_release_next;
    end
  end

  assign vc_busy     = vc_busy_reg;
  assign vc_owner    = vc_owner_reg;
  assign err_release = err_release_reg;

endmodule
